// File: rtl/cpu_ctrl_pkg.sv
// =============================================================================
// Module : cpu_ctrl_pkg
// Brief  : Shared types and constants for the RISC control unit: FSM states,
//          opcode/op encodings, writeback-select one-hots, IR field slices.
// Rev    : 1.0  initial release
// =============================================================================
`default_nettype none

package cpu_ctrl_pkg;

  // Control FSM states; HALT is only reachable when illegal-trap is built in
  typedef enum logic [2:0] {
    ST_WAIT   = 3'd0,
    ST_DECODE = 3'd1,
    ST_WIMM   = 3'd2,
    ST_GETA   = 3'd3,
    ST_GETB   = 3'd4,
    ST_ALU    = 3'd5,
    ST_WRB    = 3'd6,
    ST_HALT   = 3'd7
  } state_e;

  // Instruction classes produced by the decoder
  typedef enum logic [2:0] {
    CLS_MOVI = 3'd0,
    CLS_MOVR = 3'd1,
    CLS_ALU  = 3'd2,
    CLS_CMP  = 3'd3,
    CLS_ILL  = 3'd4
  } icls_e;

  localparam logic [2:0] OPC_MOV  = 3'b110;
  localparam logic [2:0] OPC_ALU  = 3'b101;
  localparam logic [1:0] OP_MOVI  = 2'b10;
  localparam logic [1:0] OP_MOVR  = 2'b00;
  localparam logic [1:0] OP_ADD   = 2'b00;
  localparam logic [1:0] OP_CMP   = 2'b01;
  localparam logic [1:0] OP_AND   = 2'b10;
  localparam logic [1:0] OP_MVN   = 2'b11;

  // Writeback source one-hots, shared with the datapath
  localparam logic [3:0] VSEL_NONE  = 4'b0000;
  localparam logic [3:0] VSEL_MDATA = 4'b0001;
  localparam logic [3:0] VSEL_IMM8  = 4'b0010;
  localparam logic [3:0] VSEL_PC    = 4'b0100;
  localparam logic [3:0] VSEL_C     = 4'b1000;

  // IR field positions
  localparam int OPC_HI = 15;
  localparam int OPC_LO = 13;
  localparam int OP_HI  = 12;
  localparam int OP_LO  = 11;
  localparam int RN_HI  = 10;
  localparam int RN_LO  = 8;
  localparam int RD_HI  = 7;
  localparam int RD_LO  = 5;
  localparam int SH_HI  = 4;
  localparam int SH_LO  = 3;
  localparam int RM_HI  = 2;
  localparam int RM_LO  = 0;

  function automatic logic [15:0] sext8(input logic [7:0] v);
    return {{8{v[7]}}, v};
  endfunction

  function automatic logic [15:0] sext5(input logic [4:0] v);
    return {{11{v[4]}}, v};
  endfunction

endpackage

`default_nettype wire

// File: rtl/cpu_ctrl_instr_dec.sv
// =============================================================================
// Module : instr_dec
// Brief  : Purely combinational instruction decoder. Splits the IR into its
//          fields, sign-extends the immediates and classifies the instruction.
// Rev    : 1.0  initial release
// =============================================================================
`default_nettype none

module instr_dec
  import cpu_ctrl_pkg::*;
(
  input  logic [15:0] ir_i,
  output logic [1:0]  op_o,
  output logic [2:0]  rn_o,
  output logic [2:0]  rd_o,
  output logic [1:0]  sh_o,
  output logic [2:0]  rm_o,
  output logic [15:0] sximm8_o,
  output logic [15:0] sximm5_o,
  output icls_e       cls_o,
  output logic        legal_o
);

  logic [2:0] w_opc;

  assign w_opc    = ir_i[OPC_HI:OPC_LO];
  assign op_o     = ir_i[OP_HI:OP_LO];
  assign rn_o     = ir_i[RN_HI:RN_LO];
  assign rd_o     = ir_i[RD_HI:RD_LO];
  assign sh_o     = ir_i[SH_HI:SH_LO];
  assign rm_o     = ir_i[RM_HI:RM_LO];
  assign sximm8_o = sext8(ir_i[7:0]);
  assign sximm5_o = sext5(ir_i[4:0]);

  // Map opcode/op pairs onto execution classes; anything unlisted is illegal
  always_comb begin
    cls_o = CLS_ILL;
    if (w_opc == OPC_MOV) begin
      if (op_o == OP_MOVI)      cls_o = CLS_MOVI;
      else if (op_o == OP_MOVR) cls_o = CLS_MOVR;
    end else if (w_opc == OPC_ALU) begin
      if (op_o == OP_CMP) cls_o = CLS_CMP;
      else                cls_o = CLS_ALU;
    end
  end

  assign legal_o = (cls_o != CLS_ILL);

endmodule

`default_nettype wire

// File: rtl/cpu_ctrl.sv
// =============================================================================
// Module : cpu_ctrl
// Brief  : Instruction register, decoder and control FSM driving every
//          datapath control port, one micro-step per clock.
//          Build option CPU_CTRL_TRAP_EN: illegal instructions halt the FSM
//          and raise `illegal`; otherwise they retire as no-ops.
// Rev    : 1.0  initial release
// =============================================================================
`default_nettype none

module cpu_ctrl
  import cpu_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] in,
  input  logic        load,
  input  logic        s,
  output logic        w,
  output logic [2:0]  readnum,
  output logic [2:0]  writenum,
  output logic        write,
  output logic [3:0]  vsel,
  output logic        loada,
  output logic        loadb,
  output logic        loadc,
  output logic        loads,
  output logic        asel,
  output logic        bsel,
  output logic [1:0]  shift,
  output logic [1:0]  ALUop,
  output logic [15:0] sximm8,
  output logic [15:0] sximm5
`ifdef CPU_CTRL_TRAP_EN
  ,
  output logic        illegal
`endif
);

  state_e      state_q, state_d;
  logic [15:0] ir_q, ir_d;

  logic [1:0]  w_op;
  logic [2:0]  w_rn, w_rd, w_rm;
  logic [1:0]  w_sh;
  icls_e       w_cls;
  logic        w_legal;

  instr_dec u_dec (
    .ir_i     (ir_q),
    .op_o     (w_op),
    .rn_o     (w_rn),
    .rd_o     (w_rd),
    .sh_o     (w_sh),
    .rm_o     (w_rm),
    .sximm8_o (sximm8),
    .sximm5_o (sximm5),
    .cls_o    (w_cls),
    .legal_o  (w_legal)
  );

  // IR only accepts a new word while idle
  assign ir_d = (load && (state_q == ST_WAIT)) ? in : ir_q;

  // IR and state registers, asynchronously cleared
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ir_q    <= '0;
      state_q <= ST_WAIT;
    end else begin
      ir_q    <= ir_d;
      state_q <= state_d;
    end
  end

  // Next-state and control decode, all outputs Moore-style from state and IR
  always_comb begin
    state_d  = state_q;
    w        = 1'b0;
    readnum  = 3'd0;
    writenum = 3'd0;
    write    = 1'b0;
    vsel     = VSEL_NONE;
    loada    = 1'b0;
    loadb    = 1'b0;
    loadc    = 1'b0;
    loads    = 1'b0;
    asel     = 1'b0;
    bsel     = 1'b0;
    shift    = 2'b00;
    ALUop    = 2'b00;
`ifdef CPU_CTRL_TRAP_EN
    illegal  = 1'b0;
`endif
    case (state_q)
      ST_WAIT: begin
        w = 1'b1;
        if (s) state_d = ST_DECODE;
      end
      ST_DECODE: begin
        if (!w_legal) begin
`ifdef CPU_CTRL_TRAP_EN
          state_d = ST_HALT;
`else
          state_d = ST_WAIT;
`endif
        end else begin
          case (w_cls)
            CLS_MOVI: state_d = ST_WIMM;
            CLS_MOVR: state_d = ST_GETB;
            default:  state_d = ST_GETA;
          endcase
        end
      end
      ST_WIMM: begin
        writenum = w_rn;
        vsel     = VSEL_IMM8;
        write    = 1'b1;
        state_d  = ST_WAIT;
      end
      ST_GETA: begin
        readnum = w_rn;
        loada   = 1'b1;
        state_d = ST_GETB;
      end
      ST_GETB: begin
        readnum = w_rm;
        loadb   = 1'b1;
        state_d = ST_ALU;
      end
      ST_ALU: begin
        shift = w_sh;
        // MOV reg passes the shifted Rm through as 0 + B
        if (w_cls == CLS_MOVR) begin
          asel  = 1'b1;
          ALUop = 2'b00;
        end else begin
          ALUop = w_op;
        end
        if (w_cls == CLS_CMP) begin
          loads   = 1'b1;
          state_d = ST_WAIT;
        end else begin
          loadc   = 1'b1;
          state_d = ST_WRB;
        end
      end
      ST_WRB: begin
        writenum = w_rd;
        vsel     = VSEL_C;
        write    = 1'b1;
        state_d  = ST_WAIT;
      end
`ifdef CPU_CTRL_TRAP_EN
      ST_HALT: begin
        illegal = 1'b1;
        state_d = ST_HALT;
      end
`endif
      default: state_d = ST_WAIT;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_cpu_ctrl.sv
// =============================================================================
// Module : tb_cpu_ctrl
// Brief  : Directed, table-driven bench for cpu_ctrl. Honours CPU_CTRL_TRAP_EN.
// Rev    : 1.0  initial release
// =============================================================================
`default_nettype none

module tb_cpu_ctrl;

  typedef struct packed {
    logic        w;
    logic [2:0]  rn;
    logic [2:0]  wn;
    logic        wr;
    logic [3:0]  vs;
    logic        la;
    logic        lb;
    logic        lc;
    logic        ls;
    logic        as;
    logic        bs;
    logic [1:0]  sh;
    logic [1:0]  alu;
    logic [15:0] sx8;
    logic [15:0] sx5;
  } ctl_t;

  typedef struct {
    logic        ld;
    logic        st;
    logic [15:0] ins;
    ctl_t        exp;
  } row_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] instr = 16'h0000;
  logic        load = 1'b0;
  logic        s = 1'b0;
  logic        w, write, loada, loadb, loadc, loads, asel, bsel;
  logic [2:0]  readnum, writenum;
  logic [3:0]  vsel;
  logic [1:0]  shift, ALUop;
  logic [15:0] sximm8, sximm5;
`ifdef CPU_CTRL_TRAP_EN
  logic        illegal;
`endif

  int checks = 0;
  int errors = 0;
  row_t tbl[$];
  ctl_t act;

  always #5 clk = ~clk;

  cpu_ctrl dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .in       (instr),
    .load     (load),
    .s        (s),
    .w        (w),
    .readnum  (readnum),
    .writenum (writenum),
    .write    (write),
    .vsel     (vsel),
    .loada    (loada),
    .loadb    (loadb),
    .loadc    (loadc),
    .loads    (loads),
    .asel     (asel),
    .bsel     (bsel),
    .shift    (shift),
    .ALUop    (ALUop),
    .sximm8   (sximm8),
    .sximm5   (sximm5)
`ifdef CPU_CTRL_TRAP_EN
    ,
    .illegal  (illegal)
`endif
  );

  always_comb act = {w, readnum, writenum, write, vsel, loada, loadb, loadc,
                     loads, asel, bsel, shift, ALUop, sximm8, sximm5};

  function automatic ctl_t mk(input logic wv, input logic [2:0] rn, input logic [2:0] wn,
                              input logic wr, input logic [3:0] vs, input logic la,
                              input logic lb, input logic lc, input logic ls,
                              input logic as, input logic [1:0] sh, input logic [1:0] alu,
                              input logic [15:0] sx8, input logic [15:0] sx5);
    return {wv, rn, wn, wr, vs, la, lb, lc, ls, as, 1'b0, sh, alu, sx8, sx5};
  endfunction

  function automatic ctl_t idle(input logic [15:0] a, input logic [15:0] b);
    return mk(1'b1, 3'd0, 3'd0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, a, b);
  endfunction
  function automatic ctl_t dec(input logic [15:0] a, input logic [15:0] b);
    return mk(1'b0, 3'd0, 3'd0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, a, b);
  endfunction
  function automatic ctl_t wimm(input logic [2:0] r, input logic [15:0] a, input logic [15:0] b);
    return mk(1'b0, 3'd0, r, 1'b1, 4'b0010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, a, b);
  endfunction
  function automatic ctl_t geta(input logic [2:0] r, input logic [15:0] a, input logic [15:0] b);
    return mk(1'b0, r, 3'd0, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, a, b);
  endfunction
  function automatic ctl_t getb(input logic [2:0] r, input logic [15:0] a, input logic [15:0] b);
    return mk(1'b0, r, 3'd0, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, a, b);
  endfunction
  function automatic ctl_t alu(input logic as, input logic [1:0] sh, input logic [1:0] op,
                               input logic lc, input logic ls,
                               input logic [15:0] a, input logic [15:0] b);
    return mk(1'b0, 3'd0, 3'd0, 1'b0, 4'b0000, 1'b0, 1'b0, lc, ls, as, sh, op, a, b);
  endfunction
  function automatic ctl_t wrb(input logic [2:0] r, input logic [15:0] a, input logic [15:0] b);
    return mk(1'b0, 3'd0, r, 1'b1, 4'b1000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, a, b);
  endfunction

  function automatic void add(input logic ld, input logic st, input logic [15:0] ins, input ctl_t e);
    row_t r;
    r.ld = ld; r.st = st; r.ins = ins; r.exp = e;
    tbl.push_back(r);
  endfunction

  task automatic check(input string name, input ctl_t e);
    checks++;
    if (act !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, e);
    end
  endtask

  task automatic check_bit(input string name, input logic a, input logic e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, a, e);
    end
  endtask

  // Drive inputs away from the edge, clock once, sample just after the edge
  task automatic step(input logic ld, input logic st, input logic [15:0] ins);
    @(negedge clk);
    load = ld; s = st; instr = ins;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // MOV R0,#7
    add(1'b1, 1'b0, 16'hD007, idle(16'h0007, 16'h0007));
    add(1'b0, 1'b1, 16'h0000, dec (16'h0007, 16'h0007));
    add(1'b0, 1'b0, 16'h0000, wimm(3'd0, 16'h0007, 16'h0007));
    add(1'b0, 1'b0, 16'h0000, idle(16'h0007, 16'h0007));
    // MOV R1,#-2
    add(1'b1, 1'b0, 16'hD1FE, idle(16'hFFFE, 16'hFFFE));
    add(1'b0, 1'b1, 16'h0000, dec (16'hFFFE, 16'hFFFE));
    add(1'b0, 1'b0, 16'h0000, wimm(3'd1, 16'hFFFE, 16'hFFFE));
    add(1'b0, 1'b0, 16'h0000, idle(16'hFFFE, 16'hFFFE));
    // ADD R2,R1,R0,LSL#1 with a stray load while busy
    add(1'b1, 1'b0, 16'hA148, idle(16'h0048, 16'h0008));
    add(1'b0, 1'b1, 16'h0000, dec (16'h0048, 16'h0008));
    add(1'b1, 1'b0, 16'hFFFF, geta(3'd1, 16'h0048, 16'h0008));
    add(1'b1, 1'b0, 16'hFFFF, getb(3'd0, 16'h0048, 16'h0008));
    add(1'b0, 1'b0, 16'h0000, alu (1'b0, 2'b01, 2'b00, 1'b1, 1'b0, 16'h0048, 16'h0008));
    add(1'b0, 1'b0, 16'h0000, wrb (3'd2, 16'h0048, 16'h0008));
    add(1'b0, 1'b0, 16'h0000, idle(16'h0048, 16'h0008));
    // CMP R1,R0
    add(1'b1, 1'b0, 16'hA900, idle(16'h0000, 16'h0000));
    add(1'b0, 1'b1, 16'h0000, dec (16'h0000, 16'h0000));
    add(1'b0, 1'b0, 16'h0000, geta(3'd1, 16'h0000, 16'h0000));
    add(1'b0, 1'b0, 16'h0000, getb(3'd0, 16'h0000, 16'h0000));
    add(1'b0, 1'b0, 16'h0000, alu (1'b0, 2'b00, 2'b01, 1'b0, 1'b1, 16'h0000, 16'h0000));
    add(1'b0, 1'b0, 16'h0000, idle(16'h0000, 16'h0000));
    // MVN R3,R5,LSR#1
    add(1'b1, 1'b0, 16'hB875, idle(16'h0075, 16'hFFF5));
    add(1'b0, 1'b1, 16'h0000, dec (16'h0075, 16'hFFF5));
    add(1'b0, 1'b0, 16'h0000, geta(3'd0, 16'h0075, 16'hFFF5));
    add(1'b0, 1'b0, 16'h0000, getb(3'd5, 16'h0075, 16'hFFF5));
    add(1'b0, 1'b0, 16'h0000, alu (1'b0, 2'b10, 2'b11, 1'b1, 1'b0, 16'h0075, 16'hFFF5));
    add(1'b0, 1'b0, 16'h0000, wrb (3'd3, 16'h0075, 16'hFFF5));
    add(1'b0, 1'b0, 16'h0000, idle(16'h0075, 16'hFFF5));
    // MOV R4,R2,ASR#1
    add(1'b1, 1'b0, 16'hC09A, idle(16'hFF9A, 16'hFFFA));
    add(1'b0, 1'b1, 16'h0000, dec (16'hFF9A, 16'hFFFA));
    add(1'b0, 1'b0, 16'h0000, getb(3'd2, 16'hFF9A, 16'hFFFA));
    add(1'b0, 1'b0, 16'h0000, alu (1'b1, 2'b11, 2'b00, 1'b1, 1'b0, 16'hFF9A, 16'hFFFA));
    add(1'b0, 1'b0, 16'h0000, wrb (3'd4, 16'hFF9A, 16'hFFFA));
    add(1'b0, 1'b0, 16'h0000, idle(16'hFF9A, 16'hFFFA));
    // load+s together, then s held high for a back-to-back rerun
    add(1'b1, 1'b1, 16'hD007, dec (16'h0007, 16'h0007));
    add(1'b0, 1'b1, 16'h0000, wimm(3'd0, 16'h0007, 16'h0007));
    add(1'b0, 1'b1, 16'h0000, idle(16'h0007, 16'h0007));
    add(1'b0, 1'b1, 16'h0000, dec (16'h0007, 16'h0007));
    add(1'b0, 1'b0, 16'h0000, wimm(3'd0, 16'h0007, 16'h0007));
    add(1'b0, 1'b0, 16'h0000, idle(16'h0007, 16'h0007));

    // Reset state
    #12;
    check("reset", idle(16'h0000, 16'h0000));
`ifdef CPU_CTRL_TRAP_EN
    check_bit("reset_illegal", illegal, 1'b0);
`endif
    @(negedge clk);
    reset_n = 1'b1;

    foreach (tbl[i]) begin
      step(tbl[i].ld, tbl[i].st, tbl[i].ins);
      check($sformatf("row%0d", i), tbl[i].exp);
    end

    // Asynchronous reset during GETB of an ADD
    step(1'b1, 1'b0, 16'hA148);
    step(1'b0, 1'b1, 16'h0000);
    step(1'b0, 1'b0, 16'h0000);
    step(1'b0, 1'b0, 16'h0000);
    check("pre_reset_getb", getb(3'd0, 16'h0048, 16'h0008));
    #2 reset_n = 1'b0;
    #1 check("async_reset", idle(16'h0000, 16'h0000));
    @(negedge clk);
    reset_n = 1'b1;
    step(1'b0, 1'b0, 16'h0000);
    check("post_reset_wait", idle(16'h0000, 16'h0000));

    // Illegal instruction
    step(1'b1, 1'b0, 16'h0000);
    step(1'b0, 1'b1, 16'h0000);
    check("ill_decode", dec(16'h0000, 16'h0000));
    step(1'b0, 1'b0, 16'h0000);
`ifdef CPU_CTRL_TRAP_EN
    check("halt", dec(16'h0000, 16'h0000));
    check_bit("halt_illegal", illegal, 1'b1);
    step(1'b1, 1'b1, 16'hD007);
    step(1'b1, 1'b1, 16'hD007);
    check("halt_sticky", dec(16'h0000, 16'h0000));
    check_bit("halt_illegal_sticky", illegal, 1'b1);
    @(negedge clk);
    load = 1'b0; s = 1'b0;
    reset_n = 1'b0;
    #1 check("halt_reset", idle(16'h0000, 16'h0000));
    check_bit("halt_reset_illegal", illegal, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
`else
    check("ill_noop", idle(16'h0000, 16'h0000));
    step(1'b0, 1'b0, 16'h0000);
    check("ill_stay_wait", idle(16'h0000, 16'h0000));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
